// File: rtl/data_receiver.sv
// Serial frame receiver: synchronizes the transmitter's frame/clock/data lines,
// shifts in WIDTH bits MSB first and validates frame length, with an idle timeout.
module data_receiver #(
  parameter int WIDTH   = 64,
  parameter int TIMEOUT = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             transmission,
  input  logic             serial_clk,
  input  logic             serial_data,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             frame_error,
  output logic             busy,
  output logic [7:0]       error_count,
  output logic [15:0]      frame_count
);
  localparam int BCW = $clog2(WIDTH + 2);
  localparam int TW  = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, RECV} state_t;
  state_t r_state, w_state_nxt;

  logic r_tx_meta, r_tx_sync, r_tx_dly;
  logic r_sck_meta, r_sck_sync, r_sck_dly;
  logic r_sd_meta, r_sd_sync;
  logic [2:0] r_warm;
  logic [WIDTH-1:0] r_shift, r_data;
  logic [BCW-1:0] r_bc;
  logic [TW-1:0]  r_tmo;
  logic r_valid, r_ferr, r_busy;
  logic [7:0]  r_error_count;
  logic [15:0] r_frame_count;

  logic w_tx_rise, w_tx_fall, w_sck_rise, w_start, w_good, w_bad;
  logic [BCW-1:0]   w_bc_upd;
  logic [WIDTH-1:0] w_shift_upd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_tx_meta, r_tx_sync, r_tx_dly}    <= '0;
      {r_sck_meta, r_sck_sync, r_sck_dly} <= '0;
      {r_sd_meta, r_sd_sync}              <= '0;
      r_warm                              <= '0;
    end else begin
      {r_tx_meta, r_tx_sync, r_tx_dly}    <= {transmission, r_tx_meta, r_tx_sync};
      {r_sck_meta, r_sck_sync, r_sck_dly} <= {serial_clk, r_sck_meta, r_sck_sync};
      {r_sd_meta, r_sd_sync}              <= {serial_data, r_sd_meta};
      r_warm                              <= {r_warm[1:0], 1'b1};
    end
  end

  // Edges are masked until the delayed copies hold real samples, so a line
  // already high when reset lifts is not mistaken for a fresh rise.
  assign w_tx_rise  = r_warm[2] &  r_tx_sync  & ~r_tx_dly;
  assign w_tx_fall  = r_warm[2] & ~r_tx_sync  &  r_tx_dly;
  assign w_sck_rise = r_warm[2] &  r_sck_sync & ~r_sck_dly;

  // Bit accepted in the same cycle as the frame end counts toward the length check.
  always_comb begin
    w_bc_upd    = r_bc;
    w_shift_upd = r_shift;
    if (w_sck_rise) begin
      if (r_bc < BCW'(WIDTH)) w_shift_upd = {r_shift[WIDTH-2:0], r_sd_sync};
      if (r_bc != BCW'(WIDTH + 1)) w_bc_upd = r_bc + BCW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_good      = 1'b0;
    w_bad       = 1'b0;
    case (r_state)
      IDLE: if (w_tx_rise) begin
        w_state_nxt = RECV;
        w_start     = 1'b1;
      end
      RECV: if (w_tx_fall) begin
        w_state_nxt = IDLE;
        if (w_bc_upd == BCW'(WIDTH)) w_good = 1'b1;
        else                         w_bad  = 1'b1;
      end else if (!w_sck_rise && r_tmo == TW'(TIMEOUT - 1)) begin
        w_state_nxt = IDLE;
        w_bad       = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift       <= '0;
      r_bc          <= '0;
      r_tmo         <= '0;
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_ferr        <= 1'b0;
      r_busy        <= 1'b0;
      r_error_count <= '0;
      r_frame_count <= '0;
    end else begin
      r_valid <= w_good;
      r_ferr  <= w_bad;
      r_busy  <= (w_state_nxt == RECV);
      if (w_start) begin
        r_shift <= '0;
        r_bc    <= '0;
        r_tmo   <= '0;
      end else if (r_state == RECV) begin
        r_shift <= w_shift_upd;
        r_bc    <= w_bc_upd;
        r_tmo   <= w_sck_rise ? '0 : r_tmo + TW'(1);
      end
      if (w_good) begin
        r_data        <= w_shift_upd;
        r_frame_count <= r_frame_count + 16'd1;
      end
      if (w_bad && r_error_count != 8'hFF) r_error_count <= r_error_count + 8'd1;
    end
  end

  assign data        = r_data;
  assign valid       = r_valid;
  assign frame_error = r_ferr;
  assign busy        = r_busy;
  assign error_count = r_error_count;
  assign frame_count = r_frame_count;
endmodule

// File: tb/tb_data_receiver.sv
// Directed bench for data_receiver (WIDTH=64, TIMEOUT=100): frames, errors,
// timeout, reset, simultaneous edge, counter saturation and wrap.
module tb_data_receiver;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        transmission = 1'b0, serial_clk = 1'b0, serial_data = 1'b0;
  logic [63:0] data;
  logic        valid, frame_error, busy;
  logic [7:0]  error_count;
  logic [15:0] frame_count;

  int checks = 0, fails = 0;
  int nv = 0, nf = 0, novl = 0;

  data_receiver #(.WIDTH(64), .TIMEOUT(100)) dut (
    .clk(clk), .rst_n(rst_n), .transmission(transmission), .serial_clk(serial_clk),
    .serial_data(serial_data), .data(data), .valid(valid), .frame_error(frame_error),
    .busy(busy), .error_count(error_count), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid === 1'b1) nv++;
    if (frame_error === 1'b1) nf++;
    if (valid === 1'b1 && frame_error === 1'b1) novl++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [127:0] v, input int n);
    transmission = 1'b1;
    tick(4);
    for (int i = 0; i < n; i++) begin
      serial_data = v[n-1-i];
      tick(1);
      serial_clk = 1'b1;
      tick(3);
      serial_clk = 1'b0;
      tick(2);
    end
  endtask

  // Result pulse must appear exactly at the third negedge after the fall, for one cycle.
  task automatic end_frame(input string tag, input logic g, input logic b);
    transmission = 1'b0;
    tick(2);
    chk({tag, "_early"}, 64'({valid, frame_error}), 64'(2'b00));
    tick(1);
    chk({tag, "_pulse"}, 64'({valid, frame_error}), 64'({g, b}));
    tick(1);
    chk({tag, "_after"}, 64'({valid, frame_error, busy}), 64'(3'b000));
  endtask

  initial begin
    logic [63:0] v;
    int k, nf0, nv0;

    #2 rst_n = 1'b0;
    tick(3);
    chk("rst_data", data, 64'h0);
    chk("rst_flags", 64'({valid, frame_error, busy}), 64'(3'b000));
    chk("rst_ec", 64'(error_count), 64'd0);
    chk("rst_fc", 64'(frame_count), 64'd0);
    rst_n = 1'b1;
    tick(4);

    send_bits(128'h0000_0000_0000_0000_DEAD_BEEF_0123_4567, 64);
    chk("good_busy", 64'(busy), 64'd1);
    end_frame("good", 1'b1, 1'b0);
    chk("good_data", data, 64'hDEADBEEF01234567);
    chk("good_fc", 64'(frame_count), 64'd1);
    chk("good_ec", 64'(error_count), 64'd0);

    send_bits(128'h0000_0000_0000_0000_1111_2222_3333_4444, 63);
    end_frame("short", 1'b0, 1'b1);
    chk("short_ec", 64'(error_count), 64'd1);
    chk("short_data", data, 64'hDEADBEEF01234567);

    send_bits(128'h0000_0000_0000_0003_5555_6666_7777_8888, 66);
    end_frame("ovr", 1'b0, 1'b1);
    chk("ovr_ec", 64'(error_count), 64'd2);
    chk("ovr_data", data, 64'hDEADBEEF01234567);
    chk("ovr_fc", 64'(frame_count), 64'd1);

    // last serial_clk rise lands together with the frame end
    v = 64'hA5A5_0F0F_1234_5678;
    send_bits(128'(v >> 1), 63);
    serial_data = v[0];
    tick(1);
    serial_clk = 1'b1;
    end_frame("simul", 1'b1, 1'b0);
    serial_clk = 1'b0;
    chk("simul_data", data, v);
    chk("simul_fc", 64'(frame_count), 64'd2);

    nf0 = nf;
    transmission = 1'b1;
    k = 0;
    while (busy !== 1'b1 && k < 10) begin tick(1); k++; end
    chk("stall_enter", 64'(busy), 64'd1);
    k = 0;
    while (frame_error !== 1'b1 && k < 200) begin tick(1); k++; end
    chk("stall_cycles", 64'(k), 64'd100);
    chk("stall_busy", 64'(busy), 64'd0);
    tick(1);
    chk("stall_pulse1", 64'(frame_error), 64'd0);
    transmission = 1'b0;
    tick(6);
    chk("stall_nf", 64'(nf), 64'(nf0 + 1));
    chk("stall_ec", 64'(error_count), 64'd3);
    send_bits(128'h0000_0000_0000_0000_CAFE_F00D_8BAD_BEEF, 64);
    end_frame("post_stall", 1'b1, 1'b0);
    chk("post_stall_data", data, 64'hCAFEF00D8BADBEEF);
    chk("post_stall_fc", 64'(frame_count), 64'd3);

    nv0 = nv; nf0 = nf;
    send_bits(128'h0000_0000_0000_0000_FFFF_0000_FFFF_0000, 20);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_data", data, 64'h0);
    chk("mrst_flags", 64'({valid, frame_error, busy}), 64'(3'b000));
    chk("mrst_cnt", 64'({error_count, frame_count}), 64'h0);
    tick(2);
    rst_n = 1'b1;
    tick(8);
    chk("mrst_nostart", 64'(busy), 64'd0);
    chk("mrst_nopulse", 64'({nv, nf}), 64'({nv0, nf0}));
    transmission = 1'b0;
    tick(4);
    send_bits(128'h0000_0000_0000_0000_0102_0408_1020_4080, 64);
    end_frame("mrst_good", 1'b1, 1'b0);
    chk("mrst_good_data", data, 64'h0102040810204080);
    chk("mrst_good_fc", 64'(frame_count), 64'd1);

    for (int i = 0; i < 256; i++) begin
      transmission = 1'b1;
      tick(4);
      transmission = 1'b0;
      tick(5);
    end
    chk("ec_sat", 64'(error_count), 64'd255);

    force dut.r_frame_count = 16'hFFFF;
    tick(1);
    release dut.r_frame_count;
    tick(1);
    chk("fc_preset", 64'(frame_count), 64'hFFFF);
    send_bits(128'h0000_0000_0000_0000_0F1E_2D3C_4B5A_6978, 64);
    end_frame("wrap", 1'b1, 1'b0);
    chk("fc_wrap", 64'(frame_count), 64'd0);
    chk("wrap_data", data, 64'h0F1E2D3C4B5A6978);

    tick(2);
    chk("total_valid", 64'(nv), 64'd5);
    chk("total_ferr", 64'(nf), 64'd259);
    chk("no_overlap", 64'(novl), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
